load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 155 +++++++++++++++
 tb/tb_load_store_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns a MEM-stage load or store into one data-bus access.
// It stalls the pipeline while the access is in flight and returns a sign- or
// zero-extended load result for exactly one DONE cycle.
//
// Ports
//   clk, reset                      clock and asynchronous active-low reset
//   mem_valid, MemWriteM, funct3M   MEM-stage access kind, size and sign
//   ALUResultM, WriteDataM          byte address and right-aligned store data
//   stall                           pipeline freeze (combinational)
//   ReadDataM, misaligned, bus_err  access result, valid in DONE
//   bus_req/we/addr/be/wdata        registered data-bus request
//   bus_ack, bus_rdata              data-bus response
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        stall,
  output logic [31:0] ReadDataM,
  output logic        misaligned,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} lsuStateT;

  lsuStateT        state;
  logic [CntW-1:0] waitCnt;
  logic [2:0]      funct3Q;
  logic [1:0]      addrLoQ;

  logic            isMisaligned;
  logic [3:0]      reqBe;
  logic [31:0]     reqWdata;
  logic [7:0]      laneByte;
  logic [15:0]     laneHalf;
  logic [31:0]     loadExt;

  // The pipeline is released only in DONE.
  assign stall = mem_valid && (state != DONE);

  // Alignment check, byte enables and store-data replication from the MEM-stage request.
  always_comb begin
    isMisaligned = 1'b0;
    reqBe        = 4'b1111;
    reqWdata     = WriteDataM;
    case (funct3M[1:0])
      2'b00: begin
        reqBe    = 4'b0001 << ALUResultM[1:0];
        reqWdata = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        isMisaligned = ALUResultM[0];
        reqBe        = 4'b0011 << {ALUResultM[1], 1'b0};
        reqWdata     = {2{WriteDataM[15:0]}};
      end
      default: begin
        isMisaligned = |ALUResultM[1:0];
      end
    endcase
  end

  // Lane selection and extension of the bus response, using the request latched on entry to BUSY.
  always_comb begin
    laneByte = bus_rdata[{addrLoQ, 3'b000} +: 8];
    laneHalf = bus_rdata[{addrLoQ[1], 4'b0000} +: 16];
    case (funct3Q)
      3'b000:  loadExt = {{24{laneByte[7]}}, laneByte};
      3'b001:  loadExt = {{16{laneHalf[15]}}, laneHalf};
      3'b100:  loadExt = {24'h000000, laneByte};
      3'b101:  loadExt = {16'h0000, laneHalf};
      default: loadExt = bus_rdata;
    endcase
    if (bus_we) begin
      loadExt = 32'h0000_0000;
    end
  end

  // Access sequencer with registered bus request and result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      waitCnt    <= '0;
      funct3Q    <= 3'b000;
      addrLoQ    <= 2'b00;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 32'h0000_0000;
      bus_be     <= 4'b0000;
      bus_wdata  <= 32'h0000_0000;
      ReadDataM  <= 32'h0000_0000;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_valid) begin
            if (isMisaligned) begin
              misaligned <= 1'b1;
              ReadDataM  <= 32'h0000_0000;
              state      <= DONE;
            end else begin
              bus_req   <= 1'b1;
              bus_we    <= MemWriteM;
              bus_addr  <= {ALUResultM[31:2], 2'b00};
              bus_be    <= reqBe;
              bus_wdata <= reqWdata;
              funct3Q   <= funct3M;
              addrLoQ   <= ALUResultM[1:0];
              waitCnt   <= '0;
              state     <= BUSY;
            end
          end
        end
        BUSY: begin
          // An ack in the final allowed cycle still wins over the timeout.
          if (bus_ack) begin
            ReadDataM <= loadExt;
            bus_req   <= 1'b0;
            state     <= DONE;
          end else if (waitCnt == CntW'(TIMEOUT_CYC - 1)) begin
            ReadDataM <= 32'h0000_0000;
            bus_err   <= 1'b1;
            bus_req   <= 1'b0;
            state     <= DONE;
          end else if (waitCnt != '1) begin
            waitCnt <= waitCnt + CntW'(1);
          end
        end
        DONE: begin
          misaligned <= 1'b0;
          bus_err    <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a transaction-level model predicts
// request fields, stall/request lengths and DONE results; directed vectors
// add literal expectations.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [2:0]  funct3M = 3'b000;
  logic [31:0] ALUResultM = 32'h0;
  logic [31:0] WriteDataM = 32'h0;
  logic        stall;
  logic [31:0] ReadDataM;
  logic        misaligned;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  load_store_unit #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .MemWriteM(MemWriteM),
    .funct3M(funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .stall(stall), .ReadDataM(ReadDataM), .misaligned(misaligned), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus responder configuration
  int          ackDelayCfg = -1;
  logic [31:0] rdataCfg = 32'h0;
  bit          spuriousAck = 1'b0;
  int          reqCycles = 0;

  // Bus responder: ack after ackDelayCfg request cycles; optional stray ack when idle.
  always @(posedge clk) begin
    #1;
    bus_rdata = rdataCfg;
    if (bus_req) begin
      bus_ack = (reqCycles == ackDelayCfg);
      reqCycles++;
    end else begin
      bus_ack = spuriousAck;
      reqCycles = 0;
    end
  end

  // Model expectations for the current transaction
  bit          txActive = 1'b0;
  bit          expectIdle = 1'b0;
  bit          doneSeen = 1'b0;
  logic [31:0] expAddr, expWdata, expRead;
  logic [3:0]  expBe;
  logic        expWe, expMis, expErr;
  int          expStall, expReq;
  int          stallCnt, reqCnt;
  logic [31:0] lastRead, lastAddr, lastWdata;
  logic [3:0]  lastBe;
  logic        lastMis, lastErr;
  int          lastStall, lastReq;

  function automatic int accessSize(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * int'(addr[1:0]))) & 32'hFF;
    h = (rd >> (16 * int'(addr[1]))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'h80) ? b + 32'hFFFF_FF00 : b;
      3'b001:  return (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return rd;
    endcase
  endfunction

  // Compare process: request fields every request cycle, results in the DONE cycle.
  always @(negedge clk) begin
    if (reset && txActive && !doneSeen) begin
      if (bus_req) begin
        reqCnt++;
        chk("bus_addr", bus_addr, expAddr);
        chk("bus_be", 32'(bus_be), 32'(expBe));
        chk("bus_we", 32'(bus_we), 32'(expWe));
        chk("bus_wdata", bus_wdata, expWdata);
        lastAddr = bus_addr; lastBe = bus_be; lastWdata = bus_wdata;
      end
      if (stall) begin
        stallCnt++;
      end else begin
        chk("ReadDataM", ReadDataM, expRead);
        chk("misaligned", 32'(misaligned), 32'(expMis));
        chk("bus_err", 32'(bus_err), 32'(expErr));
        chk("stall_cycles", stallCnt, expStall);
        chk("req_cycles", reqCnt, expReq);
        lastRead = ReadDataM; lastMis = misaligned; lastErr = bus_err;
        lastStall = stallCnt; lastReq = reqCnt;
        doneSeen = 1'b1;
      end
    end else if (reset && expectIdle) begin
      chk("idle_bus_req", 32'(bus_req), 32'h0);
      chk("idle_stall", 32'(stall), 32'h0);
      chk("idle_flags", 32'({misaligned, bus_err}), 32'h0);
    end
  end

  task automatic startAccess(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rd, input int ackDelay);
    int sz, busyCycles;
    bit tmo;
    expectIdle = 1'b0;
    mem_valid = 1'b1; MemWriteM = we; funct3M = f3; ALUResultM = addr; WriteDataM = wd;
    ackDelayCfg = ackDelay; rdataCfg = rd;
    sz = accessSize(f3);
    expAddr = addr & 32'hFFFF_FFFC;
    expWe = we;
    expBe = 4'(((1 << sz) - 1) << int'(addr[1:0]));
    expWdata = (sz == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
               (sz == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
    if ((addr % sz) != 0) begin
      expMis = 1'b1; expErr = 1'b0; expRead = 32'h0; expStall = 1; expReq = 0;
    end else begin
      tmo = (ackDelay < 0) || (ackDelay >= TO);
      busyCycles = tmo ? TO : ackDelay + 1;
      expMis = 1'b0; expErr = tmo; expStall = 1 + busyCycles; expReq = busyCycles;
      expRead = (tmo || we) ? 32'h0 : modelLoad(f3, addr, rd);
    end
    stallCnt = 0; reqCnt = 0; doneSeen = 1'b0; txActive = 1'b1;
  endtask

  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input int ackDelay);
    bit ok;
    startAccess(we, f3, addr, wd, rd, ackDelay);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (doneSeen) begin ok = 1'b1; break; end
    end
    if (!ok) chk("done_wait", 32'h0, 32'h1);
    mem_valid = 1'b0; txActive = 1'b0; expectIdle = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus_req", 32'(bus_req), 32'h0);
    chk("rst_bus_we", 32'(bus_we), 32'h0);
    chk("rst_bus_be", 32'(bus_be), 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_ReadDataM", ReadDataM, 32'h0);
    chk("rst_flags", 32'({misaligned, bus_err}), 32'h0);
    reset = 1'b1;
    expectIdle = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // SW, ack on the 3rd request cycle
    access(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 2);
    chk("sw_be", 32'(lastBe), 32'hF);
    chk("sw_addr", lastAddr, 32'h100);
    chk("sw_stall4", lastStall, 4);
    chk("sw_mis", 32'(lastMis), 32'h0);

    // LB / LBU from the top byte lane, immediate ack
    access(1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF_7F01, 0);
    chk("lb_data", lastRead, 32'hFFFF_FF80);
    chk("lb_stall2", lastStall, 2);
    access(1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF_7F01, 0);
    chk("lbu_data", lastRead, 32'h0000_0080);

    // SH to the upper halfword
    access(1'b1, 3'b001, 32'h302, 32'h0000_ABCD, 32'h0, 1);
    chk("sh_be", 32'(lastBe), 32'hC);
    chk("sh_wdata", lastWdata, 32'hABCD_ABCD);
    chk("sh_addr", lastAddr, 32'h300);

    // Misaligned word: no bus access
    access(1'b0, 3'b010, 32'h401, 32'h0, 32'h0, 0);
    chk("mis_req", lastReq, 0);
    chk("mis_stall1", lastStall, 1);
    chk("mis_flag", 32'(lastMis), 32'h1);
    chk("mis_data", lastRead, 32'h0);

    // Further size/lane patterns
    access(1'b0, 3'b001, 32'h202, 32'h0, 32'h8001_1234, 0);
    chk("lh_data", lastRead, 32'hFFFF_8001);
    access(1'b0, 3'b101, 32'h202, 32'h0, 32'h8001_1234, 1);
    chk("lhu_data", lastRead, 32'h0000_8001);
    access(1'b0, 3'b001, 32'h201, 32'h0, 32'h0, 0);
    access(1'b1, 3'b000, 32'h101, 32'h1234_565A, 32'h0, 0);
    chk("sb_be", 32'(lastBe), 32'h2);
    chk("sb_wdata", lastWdata, 32'h5A5A_5A5A);
    access(1'b0, 3'b000, 32'h001, 32'h0, 32'h0000_7F00, 0);
    chk("lb_pos", lastRead, 32'h0000_007F);
    access(1'b0, 3'b110, 32'h402, 32'h0, 32'h0, 0);
    access(1'b0, 3'b010, 32'h404, 32'h0, 32'h1357_9BDF, 1);

    // Timeout, then a normal access
    access(1'b0, 3'b010, 32'h500, 32'h0, 32'h0, -1);
    chk("tmo_req4", lastReq, 4);
    chk("tmo_err", 32'(lastErr), 32'h1);
    access(1'b0, 3'b010, 32'h504, 32'h0, 32'hCAFE_F00D, 0);
    chk("post_tmo_data", lastRead, 32'hCAFE_F00D);

    // Ack in the last allowed cycle is a success
    access(1'b0, 3'b010, 32'h508, 32'h0, 32'h0BAD_CAFE, TO - 1);
    chk("edge_ack_err", 32'(lastErr), 32'h0);
    chk("edge_ack_data", lastRead, 32'h0BAD_CAFE);

    // Stray acks while idle and in DONE are ignored
    spuriousAck = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    access(1'b0, 3'b010, 32'h50C, 32'h0, 32'h2468_ACE0, 1);
    chk("spur_data", lastRead, 32'h2468_ACE0);
    spuriousAck = 1'b0;

    // mem_valid withdrawn mid-access: bus still completes, pipeline not stalled
    startAccess(1'b0, 3'b010, 32'h600, 32'h0, 32'h1111_2222, 2);
    @(posedge clk); #1;
    txActive = 1'b0; mem_valid = 1'b0;
    @(negedge clk);
    chk("drop_stall", 32'(stall), 32'h0);
    chk("drop_req", 32'(bus_req), 32'h1);
    begin
      bit fell;
      fell = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (!bus_req) begin fell = 1'b1; break; end
      end
      chk("drop_req_fell", 32'(fell), 32'h1);
    end
    expectIdle = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of a busy access
    startAccess(1'b0, 3'b010, 32'h700, 32'h0, 32'h0, -1);
    repeat (2) @(posedge clk);
    #1;
    txActive = 1'b0; mem_valid = 1'b0;
    chk("pre_rst_req", 32'(bus_req), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_req", 32'(bus_req), 32'h0);
    chk("async_rst_addr", bus_addr, 32'h0);
    chk("async_rst_be", 32'(bus_be), 32'h0);
    chk("async_rst_misc", 32'({bus_we, misaligned, bus_err}), 32'h0);
    chk("async_rst_rd", ReadDataM, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    expectIdle = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    access(1'b0, 3'b010, 32'h704, 32'h0, 32'h7654_3210, 1);
    chk("post_rst_data", lastRead, 32'h7654_3210);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
